// File: rtl/el_sync_src_pkg.sv
// Shared constants, FSM state type and rail helper for the dual-rail source stage.
package el_sync_src_pkg;

  localparam int RAIL_NUM = 2;
  localparam int IN_NUM   = 3;

  localparam int RAIL_F = 0;
  localparam int RAIL_T = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Toggle mask for one link: bit value v flips rail v, the other rail holds.
  function automatic logic [RAIL_NUM-1:0] rail_flip(input logic v);
    logic [RAIL_NUM-1:0] mask;
    mask = '0;
    if (v) mask[RAIL_T] = 1'b1;
    else   mask[RAIL_F] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/el_sync_src_ack_sync.sv
// One-bit multi-stage synchroniser for a two-phase ack arriving from the self-timed adder.
module el_ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ack_i,
  output logic ack_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw ack in at the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ack_i};
  end

  // Synchroniser flops, cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign ack_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/el_sync_src.sv
// Clocked source for the dual-rail full-adder pipeline: buffers operand words and
// launches each one as a two-phase dual-rail token on links A/B/C, one at a time.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no token outstanding; launch FIFO head when one is queued
//   ST_WAIT | token in flight; wait for all three synced acks to equal phase
module el_sync_src
  import el_sync_src_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_NUM-1:0]             in_data,
  output logic [RAIL_NUM-1:0]           out_a,
  output logic [RAIL_NUM-1:0]           out_b,
  output logic [RAIL_NUM-1:0]           out_c,
  input  logic                          ack_a_i,
  input  logic                          ack_b_i,
  input  logic                          ack_c_i,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  state_t                state_q, state_d;
  logic [IN_NUM-1:0]     mem_q [FIFO_DEPTH];
  logic [IN_NUM-1:0]     mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  in_ready_q, in_ready_d;
  logic [RAIL_NUM-1:0]   out_a_q, out_a_d;
  logic [RAIL_NUM-1:0]   out_b_q, out_b_d;
  logic [RAIL_NUM-1:0]   out_c_q, out_c_d;
  logic                  phase_q, phase_d;
  logic                  err_q, err_d;
  logic [2:0]            matched_q, matched_d;

  logic [2:0]            ack_s;
  logic [2:0]            phase_vec;
  logic [IN_NUM-1:0]     head;
  logic                  wr_en;
  logic                  launch;

  el_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk(clk), .rst_n(rst), .ack_i(ack_a_i), .ack_o(ack_s[0])
  );
  el_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk(clk), .rst_n(rst), .ack_i(ack_b_i), .ack_o(ack_s[1])
  );
  el_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_c (
    .clk(clk), .rst_n(rst), .ack_i(ack_c_i), .ack_o(ack_s[2])
  );

  // FIFO bookkeeping, token launch, ack completion and protocol error detection.
  always_comb begin
    wr_en     = in_valid && in_ready_q;
    launch    = (state_q == ST_IDLE) && (level_q != '0);
    head      = mem_q[rd_ptr_q];
    phase_vec = {3{phase_q}};

    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    out_a_d   = out_a_q;
    out_b_d   = out_b_q;
    out_c_d   = out_c_q;
    phase_d   = phase_q;
    err_d     = err_q;
    matched_d = matched_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (launch) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({wr_en, launch})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    // Registered so it can never combine with a same-edge pop while full.
    in_ready_d = (level_d != LVL_FULL);

    case (state_q)
      ST_IDLE: begin
        if (ack_s != phase_vec) err_d = 1'b1;
        if (launch) begin
          out_a_d   = out_a_q ^ rail_flip(head[0]);
          out_b_d   = out_b_q ^ rail_flip(head[1]);
          out_c_d   = out_c_q ^ rail_flip(head[2]);
          phase_d   = ~phase_q;
          matched_d = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A link that already acked must not move again within the same token.
        if ((matched_q & (ack_s ^ phase_vec)) != '0) err_d = 1'b1;
        matched_d = matched_q | ~(ack_s ^ phase_vec);
        if (ack_s == phase_vec) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, FIFO and rail registers; reset drops any queued or in-flight token.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      out_c_q    <= '0;
      phase_q    <= 1'b0;
      err_q      <= 1'b0;
      matched_q  <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      in_ready_q <= in_ready_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
      out_c_q    <= out_c_d;
      phase_q    <= phase_d;
      err_q      <= err_d;
      matched_q  <= matched_d;
    end
  end

  assign in_ready = in_ready_q;
  assign level    = level_q;
  assign busy     = (state_q == ST_WAIT);
  assign err      = err_q;
  assign out_a    = out_a_q;
  assign out_b    = out_b_q;
  assign out_c    = out_c_q;

endmodule

// File: doc/el_sync_src.md
# el_sync_src

Clocked source stage that injects operand tokens into the dual-rail full-adder pipeline. It accepts binary operand words on a valid/ready interface, buffers them in a small FIFO and emits each word as one two-phase (transition-signalled) dual-rail token on links A, B and C. It then waits for the synchronised acknowledge toggles from the adder before sending the next word. It is the boundary between the clocked operand producer and the self-timed adder stage directly downstream.

## Interface
- `RAIL_NUM`, 2, rails per link; fixed at 2; other values unsupported.
- `IN_NUM`, 3, operand bits per word: bit0 → A, bit1 → B, bit2 → C.
- `FIFO_DEPTH`, 4, operand FIFO entries; power of two, ≥ 2.
- `SYNC_STAGES`, 2, flip-flop stages per ack synchroniser; ≥ 2.

Ports:
- `clk` in 1 — single clock.
- `rst` in 1 — reset, asynchronous, active-low.
- `in_valid` in 1 — operand word valid.
- `in_ready` out 1 — FIFO not full.
- `in_data` in IN_NUM — operand word.
- `out_a` / `out_b` / `out_c` out RAIL_NUM each — dual-rail link outputs, registered.
- `ack_a_i` / `ack_b_i` / `ack_c_i` in 1 each — two-phase acks from the adder; asynchronous to `clk`.
- `level` out $clog2(FIFO_DEPTH)+1 — FIFO occupancy.
- `busy` out 1 — token in flight (FSM in WAIT).
- `err` out 1 — sticky protocol error.

## Operation
- Encoding: a token with bit value v on a link toggles rail v of that link. The other rail holds. Exactly one rail per link toggles per token.
- Ack: each link's ack toggles once per consumed token. Each ack goes through its own SYNC_STAGES synchroniser.
- `phase` register: toggles on every launch. A token is complete when all three synced acks equal `phase`.
- FIFO:
  - Write when `in_valid && in_ready`.
  - Read (pop) on launch.
  - Simultaneous write and pop when full is not allowed, because `in_ready` is registered from `level`.
  - Simultaneous write and pop when not full leaves `level` unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty is derived from `level`.
- FSM, two states:
  - IDLE: if FIFO not empty → pop head, toggle the selected rail on each link, toggle `phase`, go to WAIT. Otherwise stay.
  - WAIT: if all three synced acks == `phase` → IDLE. Otherwise stay.
- Error (sets `err`, which stays set until reset):
  - In IDLE: any synced ack ≠ `phase`.
  - In WAIT: any synced ack toggles away from `phase` after having matched it.
  - The FSM continues normally after an error.
- Reset (`rst` low, asynchronous):
  - `out_a`/`out_b`/`out_c` = 2'b00, `phase` = 0, all synchroniser flops = 0.
  - FIFO empty: `level` = 0, `in_ready` = 0 during reset, 1 on the first edge after release.
  - FSM = IDLE, `busy` = 0, `err` = 0.
  - Reset mid-token discards the in-flight token and all FIFO contents. The downstream stage must be reset in the same window.

## Timing
- `in_ready` and `in_data` are sampled at edge E0. Earliest rail toggle is at E1, if FIFO was empty and FSM was IDLE.
- Rails change only on the launch edge and stay stable until the next launch. There is no glitch path from FIFO to rails.
- Ack visibility: an ack transition settled before edge Ek appears at the synchroniser output after edge Ek+SYNC_STAGES−1.
- WAIT → IDLE on the edge after all synced acks match. The next launch is one edge later.
- Minimum token period = 2 + SYNC_STAGES cycles plus the adder's loop delay.
- `busy` = 1 exactly in WAIT. `level` is updated on the write/pop edge.
- Throughput limit: one token outstanding. No launch in WAIT.

## Structure
- Shared package: `RAIL_NUM`, `IN_NUM` constants; FSM state enum (`ST_IDLE`, `ST_WAIT`); rail-index localparams (`RAIL_F` = 0, `RAIL_T` = 1).
- Sub-module `el_ack_sync`: one-bit, SYNC_STAGES-deep synchroniser with async active-low reset; instantiated three times.
- The FIFO stays inline: small register array with pointers.

## Test plan
- Reset then idle: `rst` low → all rails 00, `level` 0, `busy`/`err` 0; after release `in_ready` = 1 and no rail activity.
- Single token: push `in_data` = 3'b101 → at E1 `out_a` = 10, `out_b` = 01, `out_c` = 10, `busy` = 1. Toggle all acks → `busy` drops SYNC_STAGES+1 edges later.
- Back-to-back: push 3'b000 then 3'b111 → second launch only after all acks toggle. Rails are then `out_a` = `out_b` = `out_c` = 11 (both rails toggled once each).
- Partial ack: toggle only `ack_a_i` and `ack_b_i` → FSM stays in WAIT and `out_*` are stable. Toggling `ack_c_i` completes the token.
- FIFO full/wrap: push FIFO_DEPTH+3 words with acks withheld → `in_ready` = 0 at `level` = FIFO_DEPTH. Release acks → all words are emitted in order with no loss or duplication.
- Spurious ack and mid-token reset: toggle `ack_b_i` in IDLE → `err` = 1 and stays set. Then assert `rst` while in WAIT → outputs return to reset values immediately.
